mem_requester: RTL and testbench
================================

// Module: mem_requester
// PURPOSE
//  Core-side initiator for the shared-memory arbiter. Accepts fetch/load/store commands from the core,
//  raises rom_rd / ram_rd / ram_wr, waits for the matching grant, runs the access for a fixed latency,
//  returns data and a done pulse, then drops the request and waits for the grant to clear.
//  The arbiter samples on negedge clk and this block runs on posedge clk.
// PARAMETERS
//  ADDR_W   8   address width, ROM and RAM
//  DATA_W   8   data width
//  ROM_LAT  1   posedge cycles the ROM access is held after the grant is seen (>=1)
//  RAM_LAT  1   posedge cycles the RAM access is held after the grant is seen (>=1)
//  TIMEOUT  16  grant-wait limit in cycles (used only with MEM_REQ_TIMEOUT_EN)
// PORTS
//  clk            in   1       clock, posedge
//  reset          in   1       async, active-high
//  fetch_req      in   1       core wants an instruction; held until fetch_done
//  fetch_addr     in   ADDR_W  ROM address
//  load_req       in   1       core wants a RAM read; held until ls_done
//  store_req      in   1       core wants a RAM write; held until ls_done
//  ls_addr        in   ADDR_W  RAM address
//  store_data     in   DATA_W  RAM write data
//  fetch_done     out  1       1-cycle pulse; fetch_data valid on it
//  fetch_data     out  DATA_W  captured ROM word, held until next fetch
//  ls_done        out  1       1-cycle pulse; load/store complete
//  load_data      out  DATA_W  captured RAM word, held until next load
//  mem_err        out  1       1-cycle pulse on grant timeout (0 without macro)
//  rom_rd         out  1       ROM request to arbiter
//  ram_rd         out  1       RAM read request to arbiter
//  ram_wr         out  1       RAM write request to arbiter
//  rom_garant     in   1       ROM grant from arbiter
//  ram_garant_rd  in   1       RAM read grant
//  ram_garant_wr  in   1       RAM write grant
//  rom_addr       out  ADDR_W  registered; stable from REQ through ACCESS
//  rom_q          in   DATA_W  ROM read data
//  ram_addr       out  ADDR_W  registered; stable from REQ through ACCESS
//  ram_d          out  DATA_W  registered write data
//  ram_q          in   DATA_W  RAM read data
//  ram_we         out  1       write strobe: 1 only in ACCESS of a store
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; all outputs 0, including data/addr registers; requests drop at once.
//  States: IDLE -> REQ -> ACCESS -> RELEASE -> IDLE. One transaction at a time.
//  IDLE: select load, then store, then fetch. load+store together: load wins, store is served next.
//   Latch addr/data and kind; go to REQ with exactly one request line high.
//  REQ: hold the request. At the first posedge where the matching grant=1, go to ACCESS with cnt=1.
//   A non-matching grant is ignored.
//  ACCESS: cnt increments each cycle. When cnt==LAT (ROM_LAT or RAM_LAT), in that cycle:
//   capture rom_q/ram_q into fetch_data/load_data; pulse fetch_done or ls_done; drop the request;
//   go to RELEASE. ram_we=1 for every ACCESS cycle of a store.
//  RELEASE: request low. Wait until the matching grant is 0, so the arbiter has freed its slot; then IDLE.
//   No new request is raised while any grant is still high.
//  Minimum turnaround: LAT=1 gives a done pulse 1 posedge after the grant is seen; the next request rises
//   at least 2 cycles later.
//  Core dropping a req mid-transaction: ignored; the transaction completes and done still pulses.
//  Grant dropping during ACCESS (protocol violation): the access still completes; the violation is not flagged.
// CONFIGURATION
//  MEM_REQ_TIMEOUT_EN defined: a counter runs in REQ. On TIMEOUT cycles with no grant: drop the request,
//   pulse mem_err, give no done, go to RELEASE. The core must re-issue.
//  Not defined: REQ waits forever; mem_err tied 0; no counter is built.
// STRUCTURE
//  mem_req_pkg: state enum (IDLE/REQ/ACCESS/RELEASE), kind codes (K_FETCH/K_LOAD/K_STORE),
//   counter width function clog2.
//  Sub-module mem_req_timer: loadable up-counter with terminal-count flag. One instance serves the
//   latency count; a second serves the timeout and exists only under the macro.
// TESTING (bench models arbiter: grant on negedge after request, clear on negedge after drop)
//  fetch_req, fetch_addr=0x12, rom_q=0xA5, ROM_LAT=1 -> rom_rd 1 cycle then grant; fetch_done 1 cycle;
//   fetch_data=0xA5; rom_rd low before done+1.
//  store_req ls_addr=0x40 store_data=0x3C, RAM_LAT=2 -> ram_wr, ram_we high 2 cycles with addr 0x40 and
//   data 0x3C; ls_done once.
//  load_req+fetch_req together, ram_q=0x77 -> RAM read first, load_data=0x77; ROM request not raised
//   until ram_garant_rd=0.
//  load_req+store_req together -> load completes, then store; two ls_done pulses; no overlap of
//   ram_rd/ram_wr.
//  reset asserted in ACCESS -> same cycle: all request lines, ram_we and done pulses 0; state IDLE.
//  [MEM_REQ_TIMEOUT_EN, TIMEOUT=16] grant withheld -> rom_rd drops after 16 cycles, mem_err pulses once,
//   fetch_done never pulses.

Source files
------------

// File: rtl/mem_req_pkg.sv
// Shared types and helpers for the core-side memory requester.
package mem_req_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      ACCESS  = 2'd2,
      RELEASE = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      K_FETCH = 2'd0,
      K_LOAD  = 2'd1,
      K_STORE = 2'd2
   } kind_t;

   // Bits needed to hold values 0 .. value-1, never less than one bit.
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result = result + 1;
         remaining = remaining >> 1;
      end
      if (result < 1) begin
         result = 1;
      end
      return result;
   endfunction

endpackage

// File: rtl/mem_req_timer.sv
// Loadable up-counter with a terminal-count flag (count == limit).
module mem_req_timer #(
   parameter int W = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic         en,
   input  logic [W-1:0] load_val,
   input  logic [W-1:0] limit,
   output logic         tc
);

   logic [W-1:0] count;

   // Load takes priority over counting so a fresh phase always starts from load_val.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (load) begin
         count <= load_val;
      end else if (en) begin
         count <= count + 1'b1;
      end
   end

   assign tc = (count == limit);

endmodule

// File: rtl/mem_requester.sv
// Core-side initiator for the shared-memory arbiter: one fetch/load/store
// transaction at a time through IDLE -> REQ -> ACCESS -> RELEASE.
// Optional grant-wait timeout is built when MEM_REQ_TIMEOUT_EN is defined.
module mem_requester
   import mem_req_pkg::*;
#(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int ROM_LAT = 1,
   parameter int RAM_LAT = 1,
   parameter int TIMEOUT = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_req,
   input  logic [ADDR_W-1:0] fetch_addr,
   input  logic              load_req,
   input  logic              store_req,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] store_data,
   output logic              fetch_done,
   output logic [DATA_W-1:0] fetch_data,
   output logic              ls_done,
   output logic [DATA_W-1:0] load_data,
   output logic              mem_err,
   output logic              rom_rd,
   output logic              ram_rd,
   output logic              ram_wr,
   input  logic              rom_garant,
   input  logic              ram_garant_rd,
   input  logic              ram_garant_wr,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_q,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_d,
   input  logic [DATA_W-1:0] ram_q,
   output logic              ram_we
);

   localparam int LAT_MAX = (ROM_LAT > RAM_LAT) ? ROM_LAT : RAM_LAT;
   localparam int LAT_W   = clog2(LAT_MAX + 1);
   localparam logic [LAT_W-1:0] ROM_LIM = LAT_W'(ROM_LAT);
   localparam logic [LAT_W-1:0] RAM_LIM = LAT_W'(RAM_LAT);

   state_t           state;
   state_t           state_next;
   kind_t            kind;
   kind_t            kind_sel;
   logic             start;
   logic             finish;
   logic             any_grant;
   logic             match_grant;
   logic             lat_load;
   logic             lat_en;
   logic             lat_tc;
   logic             timeout_tc;
   logic             req_active;
   logic [LAT_W-1:0] lat_limit;

   assign any_grant = rom_garant | ram_garant_rd | ram_garant_wr;
   assign lat_limit = (kind == K_FETCH) ? ROM_LIM : RAM_LIM;

   // Pick the grant line that belongs to the transaction in flight.
   always_comb begin
      match_grant = 1'b0;
      case (kind)
         K_FETCH: match_grant = rom_garant;
         K_LOAD:  match_grant = ram_garant_rd;
         K_STORE: match_grant = ram_garant_wr;
         default: match_grant = 1'b0;
      endcase
   end

   // State register; reset drops straight to IDLE so all requests fall at once.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state logic: launch only when the arbiter has no grant outstanding,
   // and leave RELEASE only once our own grant has cleared.
   always_comb begin
      state_next = state;
      kind_sel   = kind;
      start      = 1'b0;
      finish     = 1'b0;
      lat_load   = 1'b0;
      lat_en     = 1'b0;
      case (state)
         IDLE: begin
            if (!any_grant && (load_req || store_req || fetch_req)) begin
               start      = 1'b1;
               state_next = REQ;
               if (load_req) begin
                  kind_sel = K_LOAD;
               end else if (store_req) begin
                  kind_sel = K_STORE;
               end else begin
                  kind_sel = K_FETCH;
               end
            end
         end
         REQ: begin
            if (match_grant) begin
               lat_load   = 1'b1;
               state_next = ACCESS;
            end else if (timeout_tc) begin
               state_next = RELEASE;
            end
         end
         ACCESS: begin
            lat_en = 1'b1;
            if (lat_tc) begin
               finish     = 1'b1;
               state_next = RELEASE;
            end
         end
         RELEASE: begin
            if (!match_grant) begin
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Latch the command at launch, capture read data and pulse done at the end of ACCESS.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         kind       <= K_FETCH;
         rom_addr   <= '0;
         ram_addr   <= '0;
         ram_d      <= '0;
         fetch_data <= '0;
         load_data  <= '0;
         fetch_done <= 1'b0;
         ls_done    <= 1'b0;
      end else begin
         fetch_done <= finish && (kind == K_FETCH);
         ls_done    <= finish && (kind != K_FETCH);
         if (start) begin
            kind <= kind_sel;
            if (kind_sel == K_FETCH) begin
               rom_addr <= fetch_addr;
            end else begin
               ram_addr <= ls_addr;
               if (kind_sel == K_STORE) begin
                  ram_d <= store_data;
               end
            end
         end
         if (finish) begin
            if (kind == K_FETCH) begin
               fetch_data <= rom_q;
            end else if (kind == K_LOAD) begin
               load_data <= ram_q;
            end
         end
      end
   end

   assign req_active = (state == REQ) || (state == ACCESS);
   assign rom_rd     = req_active && (kind == K_FETCH);
   assign ram_rd     = req_active && (kind == K_LOAD);
   assign ram_wr     = req_active && (kind == K_STORE);
   assign ram_we     = (state == ACCESS) && (kind == K_STORE);

   // Latency counter starts at 1 on the grant edge; terminal count ends ACCESS.
   mem_req_timer #(
      .W(LAT_W)
   ) u_lat_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (lat_load),
      .en       (lat_en),
      .load_val (LAT_W'(1)),
      .limit    (lat_limit),
      .tc       (lat_tc)
   );

`ifdef MEM_REQ_TIMEOUT_EN
   localparam int TO_W = clog2(TIMEOUT + 1);

   // Grant-wait counter cleared at launch; terminal count is the last REQ cycle.
   mem_req_timer #(
      .W(TO_W)
   ) u_timeout_timer (
      .clk      (clk),
      .reset    (reset),
      .load     (start),
      .en       (state == REQ),
      .load_val ('0),
      .limit    (TO_W'(TIMEOUT - 1)),
      .tc       (timeout_tc)
   );

   // One-cycle error pulse when REQ gives up without a grant.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mem_err <= 1'b0;
      end else begin
         mem_err <= (state == REQ) && !match_grant && timeout_tc;
      end
   end
`else
   assign timeout_tc = 1'b0;
   assign mem_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem_requester.sv
// Self-checking bench for mem_requester: negedge arbiter model, bus monitor,
// table-driven directed transactions, random transactions and reset/timeout sequences.
module tb_mem_requester;

   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 8;
   localparam int ROM_LAT = 1;
   localparam int RAM_LAT = 2;
   localparam int TIMEOUT = 16;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              fetch_req = 1'b0;
   logic [ADDR_W-1:0] fetch_addr = '0;
   logic              load_req = 1'b0;
   logic              store_req = 1'b0;
   logic [ADDR_W-1:0] ls_addr = '0;
   logic [DATA_W-1:0] store_data = '0;
   logic              fetch_done;
   logic [DATA_W-1:0] fetch_data;
   logic              ls_done;
   logic [DATA_W-1:0] load_data;
   logic              mem_err;
   logic              rom_rd;
   logic              ram_rd;
   logic              ram_wr;
   logic              rom_garant = 1'b0;
   logic              ram_garant_rd = 1'b0;
   logic              ram_garant_wr = 1'b0;
   logic [ADDR_W-1:0] rom_addr;
   logic [DATA_W-1:0] rom_q = '0;
   logic [ADDR_W-1:0] ram_addr;
   logic [DATA_W-1:0] ram_d;
   logic [DATA_W-1:0] ram_q = '0;
   logic              ram_we;

   always #5 clk = ~clk;

   mem_requester #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .ROM_LAT (ROM_LAT),
      .RAM_LAT (RAM_LAT),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .fetch_req     (fetch_req),
      .fetch_addr    (fetch_addr),
      .load_req      (load_req),
      .store_req     (store_req),
      .ls_addr       (ls_addr),
      .store_data    (store_data),
      .fetch_done    (fetch_done),
      .fetch_data    (fetch_data),
      .ls_done       (ls_done),
      .load_data     (load_data),
      .mem_err       (mem_err),
      .rom_rd        (rom_rd),
      .ram_rd        (ram_rd),
      .ram_wr        (ram_wr),
      .rom_garant    (rom_garant),
      .ram_garant_rd (ram_garant_rd),
      .ram_garant_wr (ram_garant_wr),
      .rom_addr      (rom_addr),
      .rom_q         (rom_q),
      .ram_addr      (ram_addr),
      .ram_d         (ram_d),
      .ram_q         (ram_q),
      .ram_we        (ram_we)
   );

   // Observed / expected transaction record; kind 0=fetch 1=load 2=store.
   typedef struct {
      int kind;
      int addr;
      int data;
      int acc;
      int waitc;
      int we;
   } rec_t;

   typedef struct {
      logic       ld;
      logic       st;
      logic       fe;
      logic [7:0] faddr;
      logic [7:0] laddr;
      logic [7:0] sdata;
      logic [7:0] romq;
      logic [7:0] ramq;
      int         dly;
      logic [7:0] exp_fetch;
      logic [7:0] exp_load;
      int         exp_fd;
      int         exp_lsd;
   } vec_t;

   int   checks = 0;
   int   errors = 0;
   logic withhold = 1'b0;
   int   rel_dly = 0;
   int   rom_hold = 0;
   int   rd_hold = 0;
   int   wr_hold = 0;

   rec_t       obs_q[$];
   int         acc_cycles = 0;
   int         wait_cycles = 0;
   int         we_cycles = 0;
   int         viol_overlap = 0;
   int         viol_rise = 0;
   int         viol_addr = 0;
   int         err_pulses = 0;
   int         fetch_pulses = 0;
   int         ls_pulses = 0;
   int         last_kind = 0;
   logic [7:0] last_addr = '0;
   logic [7:0] store_seen = '0;
   logic       prev_any = 1'b0;
   logic       any_req;
   logic [7:0] model_fetch = '0;
   logic [7:0] model_load = '0;

   task automatic check_output(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // One arbiter channel: grant on the negedge after the request, clear dly negedges after the drop.
   task automatic arb_channel(input logic req, input logic g_in, input int c_in,
                              output logic g_out, output int c_out);
      g_out = g_in;
      c_out = c_in;
      if (req) begin
         if (!withhold) begin
            g_out = 1'b1;
            c_out = rel_dly;
         end
      end else if (g_in) begin
         if (c_in > 0) begin
            c_out = c_in - 1;
         end else begin
            g_out = 1'b0;
         end
      end
   endtask

   // Arbiter model runs on the falling edge.
   always @(negedge clk) begin
      arb_channel(rom_rd, rom_garant, rom_hold, rom_garant, rom_hold);
      arb_channel(ram_rd, ram_garant_rd, rd_hold, ram_garant_rd, rd_hold);
      arb_channel(ram_wr, ram_garant_wr, wr_hold, ram_garant_wr, wr_hold);
   end

   // Bus monitor: samples just after each rising edge and turns activity into records.
   always @(posedge clk) begin
      #1;
      if (reset) begin
         prev_any = 1'b0;
      end else begin
         any_req = rom_rd | ram_rd | ram_wr;
         if ((int'(rom_rd) + int'(ram_rd) + int'(ram_wr)) > 1) viol_overlap++;
         if (any_req && !prev_any) begin
            if (rom_garant | ram_garant_rd | ram_garant_wr) viol_rise++;
            acc_cycles  = 0;
            wait_cycles = 0;
            we_cycles   = 0;
            last_addr   = rom_rd ? rom_addr : ram_addr;
         end
         if (any_req) begin
            last_kind = rom_rd ? 0 : (ram_rd ? 1 : 2);
            if ((rom_rd ? rom_addr : ram_addr) != last_addr) viol_addr++;
            if ((rom_rd && rom_garant) || (ram_rd && ram_garant_rd) || (ram_wr && ram_garant_wr))
               acc_cycles++;
            else
               wait_cycles++;
         end
         if (ram_we) begin
            we_cycles++;
            store_seen = ram_d;
         end
         if (mem_err) err_pulses++;
         if (fetch_done) begin
            fetch_pulses++;
            obs_q.push_back('{0, int'(last_addr), int'(fetch_data), acc_cycles, wait_cycles, we_cycles});
         end
         if (ls_done) begin
            ls_pulses++;
            obs_q.push_back('{last_kind, int'(last_addr),
                              (last_kind == 1) ? int'(load_data) : int'(store_seen),
                              acc_cycles, wait_cycles, we_cycles});
         end
         prev_any = any_req;
      end
   end

   // Core model for one command set; the reference model predicts the served order and results.
   task automatic apply_stimulus(input logic ld, input logic st, input logic fe,
                                 input logic [7:0] faddr, input logic [7:0] laddr,
                                 input logic [7:0] sdata, input logic [7:0] romq,
                                 input logic [7:0] ramq, input int dly);
      rec_t exp_q[$];
      int   cycles;
      int   n;
      if (ld) exp_q.push_back('{1, int'(laddr), int'(ramq), RAM_LAT, 1, 0});
      if (st) exp_q.push_back('{2, int'(laddr), int'(sdata), RAM_LAT, 1, RAM_LAT});
      if (fe) exp_q.push_back('{0, int'(faddr), int'(romq), ROM_LAT, 1, 0});
      if (ld) model_load = ramq;
      if (fe) model_fetch = romq;
      @(negedge clk);
      obs_q.delete();
      viol_overlap = 0;
      viol_rise    = 0;
      viol_addr    = 0;
      rel_dly      = dly;
      fetch_addr   = faddr;
      ls_addr      = laddr;
      store_data   = sdata;
      rom_q        = romq;
      ram_q        = ramq;
      load_req     = ld;
      store_req    = st;
      fetch_req    = fe;
      cycles       = 0;
      while ((load_req || store_req || fetch_req) && cycles < 300) begin
         @(posedge clk);
         #1;
         cycles++;
         if (fetch_done) fetch_req = 1'b0;
         if (ls_done) begin
            if (load_req) load_req = 1'b0;
            else store_req = 1'b0;
         end
      end
      check_output("txn_complete", int'(cycles < 300), 1);
      load_req  = 1'b0;
      store_req = 1'b0;
      fetch_req = 1'b0;
      repeat (4 + dly) @(posedge clk);
      @(negedge clk);
      check_output("op_count", obs_q.size(), exp_q.size());
      n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
      for (int i = 0; i < n; i++) begin
         check_output("op_kind", obs_q[i].kind, exp_q[i].kind);
         check_output("op_addr", obs_q[i].addr, exp_q[i].addr);
         check_output("op_data", obs_q[i].data, exp_q[i].data);
         check_output("op_access_cycles", obs_q[i].acc, exp_q[i].acc);
         check_output("op_wait_cycles", obs_q[i].waitc, exp_q[i].waitc);
         check_output("op_we_cycles", obs_q[i].we, exp_q[i].we);
      end
      check_output("fetch_data_held", int'(fetch_data), int'(model_fetch));
      check_output("load_data_held", int'(load_data), int'(model_load));
      check_output("req_overlap", viol_overlap, 0);
      check_output("req_rise_under_grant", viol_rise, 0);
      check_output("addr_stable", viol_addr, 0);
   endtask

   initial begin
      automatic vec_t vecs[5];
      int         fd0;
      int         lsd0;
      int         err0;
      int         cycles;
      logic [2:0] mask;

      vecs[0] = '{1'b0, 1'b0, 1'b1, 8'h12, 8'h00, 8'h00, 8'hA5, 8'h00, 0, 8'hA5, 8'h00, 1, 0};
      vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h40, 8'h3C, 8'hA5, 8'h00, 0, 8'hA5, 8'h00, 0, 1};
      vecs[2] = '{1'b1, 1'b0, 1'b1, 8'h34, 8'h10, 8'h00, 8'h5A, 8'h77, 3, 8'h5A, 8'h77, 1, 1};
      vecs[3] = '{1'b1, 1'b1, 1'b0, 8'h00, 8'h20, 8'h99, 8'h5A, 8'h11, 1, 8'h5A, 8'h11, 0, 2};
      vecs[4] = '{1'b1, 1'b1, 1'b1, 8'hFF, 8'h00, 8'h01, 8'hC3, 8'h3E, 0, 8'hC3, 8'h3E, 1, 2};

      #1 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_output("rst_rom_rd", int'(rom_rd), 0);
      check_output("rst_ram_rd", int'(ram_rd), 0);
      check_output("rst_ram_wr", int'(ram_wr), 0);
      check_output("rst_ram_we", int'(ram_we), 0);
      check_output("rst_fetch_done", int'(fetch_done), 0);
      check_output("rst_ls_done", int'(ls_done), 0);
      check_output("rst_mem_err", int'(mem_err), 0);
      check_output("rst_fetch_data", int'(fetch_data), 0);
      check_output("rst_load_data", int'(load_data), 0);
      check_output("rst_rom_addr", int'(rom_addr), 0);
      check_output("rst_ram_addr", int'(ram_addr), 0);
      check_output("rst_ram_d", int'(ram_d), 0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         fd0  = fetch_pulses;
         lsd0 = ls_pulses;
         apply_stimulus(vecs[i].ld, vecs[i].st, vecs[i].fe, vecs[i].faddr, vecs[i].laddr,
                        vecs[i].sdata, vecs[i].romq, vecs[i].ramq, vecs[i].dly);
         check_output("vec_fetch_data", int'(fetch_data), int'(vecs[i].exp_fetch));
         check_output("vec_load_data", int'(load_data), int'(vecs[i].exp_load));
         check_output("vec_fetch_done_count", fetch_pulses - fd0, vecs[i].exp_fd);
         check_output("vec_ls_done_count", ls_pulses - lsd0, vecs[i].exp_lsd);
      end

      // Reset in the middle of a store access.
      @(negedge clk);
      rel_dly    = 0;
      ls_addr    = 8'h66;
      store_data = 8'hE7;
      store_req  = 1'b1;
      cycles     = 0;
      while (!ram_we && cycles < 50) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      check_output("reach_access", int'(ram_we), 1);
      @(negedge clk);
      #2 reset = 1'b1;
      #1;
      check_output("midrst_ram_wr", int'(ram_wr), 0);
      check_output("midrst_rom_rd", int'(rom_rd), 0);
      check_output("midrst_ram_rd", int'(ram_rd), 0);
      check_output("midrst_ram_we", int'(ram_we), 0);
      check_output("midrst_ls_done", int'(ls_done), 0);
      check_output("midrst_fetch_done", int'(fetch_done), 0);
      check_output("midrst_ram_addr", int'(ram_addr), 0);
      check_output("midrst_ram_d", int'(ram_d), 0);
      check_output("midrst_fetch_data", int'(fetch_data), 0);
      check_output("midrst_load_data", int'(load_data), 0);
      store_req = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset       = 1'b0;
      model_fetch = '0;
      model_load  = '0;
      apply_stimulus(1'b0, 1'b0, 1'b1, 8'h81, 8'h00, 8'h00, 8'h4B, 8'h00, 0);

      // Random command mixes against the reference model.
      for (int i = 0; i < 40; i++) begin
         mask = 3'($urandom_range(1, 7));
         apply_stimulus(mask[2], mask[1], mask[0], 8'($urandom), 8'($urandom), 8'($urandom),
                        8'($urandom), 8'($urandom), int'($urandom_range(0, 2)));
      end

`ifdef MEM_REQ_TIMEOUT_EN
      // Grant withheld: the fetch must give up after TIMEOUT cycles with one error pulse.
      @(negedge clk);
      fd0        = fetch_pulses;
      err0       = err_pulses;
      withhold   = 1'b1;
      fetch_addr = 8'h55;
      fetch_req  = 1'b1;
      cycles     = 0;
      while (!mem_err && cycles < 100) begin
         @(posedge clk);
         #1;
         cycles++;
      end
      check_output("timeout_seen", int'(mem_err), 1);
      fetch_req = 1'b0;
      @(negedge clk);
      check_output("timeout_rom_rd_cycles", wait_cycles, TIMEOUT);
      check_output("timeout_rom_rd_low", int'(rom_rd), 0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      withhold = 1'b0;
      check_output("timeout_err_pulses", err_pulses - err0, 1);
      check_output("timeout_no_fetch_done", fetch_pulses - fd0, 0);
      check_output("mem_err_total", err_pulses, 1);
`else
      check_output("mem_err_total", err_pulses, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
